id_recv: RTL and testbench
==========================

// Module: id_recv
// PURPOSE
//  Receive-side companion of the ID transmit path. Snoops the core's load traffic on the
//  ex_to_mem bus. Captures every byte the core reads from the UART RX data register into a
//  small FIFO and checks the byte stream against the fixed 10-char student ID "2023211013".
//  Sits beside ex/ex_to_mem and drives match/done status back to ex.
// PARAMETERS
//  RXDATA_ADDR  32'h30000010  UART RX data register address that is snooped
//  ID_LEN       10            expected character count (1..15)
//  FIFO_DEPTH   4             capture FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1   system clock, all flops on posedge
//  rst             in   1   asynchronous reset, active-low
//  recv_start_i    in   1   level enable from ex; must stay high for the whole reception
//  ex_mem_req_i    in   1   memory access request
//  ex_mem_we_i     in   1   1 = write, 0 = read
//  ex_mem_raddr_i  in   32  read address
//  ex_mem_rdata_i  in   32  read data; byte in [7:0]
//  rx_pop_i        in   1   consumer pops the FIFO head
//  rx_data_o       out  8   FIFO head byte; 8'h00 when empty
//  rx_valid_o      out  1   FIFO not empty
//  char_cnt_o      out  4   characters captured this session
//  busy_o          out  1   session in progress
//  done_o          out  1   ID_LEN characters received
//  id_ok_o         out  1   all ID_LEN chars matched; valid while done_o=1
//  overflow_o      out  1   sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//  Reset
//   - rst=0: state=IDLE; FIFO empty; all outputs 0; mismatch flag 0; takes effect immediately.
//   - Reset mid-session discards all state.
//  Capture event
//   - hit = ex_mem_req_i & ~ex_mem_we_i & (ex_mem_raddr_i==RXDATA_ADDR).
//   - cap = hit & ~hit_q, where hit_q is hit registered. A multi-cycle stalled read counts once.
//  Expected ROM, index 0..9: 8'h32,30,32,33,32,31,31,30,31,33.
//  FSM
//   - IDLE:    recv_start_i=1 -> COLLECT. Clears char_cnt, mismatch, overflow and the FIFO.
//              busy_o=1 from the next cycle.
//   - COLLECT: on cap:
//       - rdata[7:0] != ROM[char_cnt] sets mismatch (sticky).
//       - Byte is pushed to the FIFO, or dropped with overflow_o<=1 if the FIFO is full
//         and not popping that cycle.
//       - char_cnt increments.
//       - When char_cnt becomes ID_LEN -> DONE on the same edge:
//         done_o<=1, busy_o<=0, id_ok_o<=~(mismatch | this byte mismatched).
//     - recv_start_i=0 -> IDLE (abort). busy_o<=0; done_o and id_ok_o stay 0.
//       The FIFO keeps its contents.
//   - DONE: outputs held; cap is ignored.
//     recv_start_i=0 -> IDLE; done_o, id_ok_o and char_cnt_o clear.
//  Latency: a byte is visible on rx_data_o/rx_valid_o one cycle after the cap cycle.
//  FIFO
//   - Registered storage; rx_data_o is read combinationally at the read pointer.
//   - Pop only when rx_valid_o=1; pop on empty is ignored.
//   - Push and pop in the same cycle when full: both occur, no overflow.
//   - Push and pop in the same cycle when empty: the push happens, the pop is ignored.
//   - Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
//   - The FIFO drains in any state, including IDLE after an abort.
// TESTING
//  T1 rst low mid-COLLECT with 3 bytes held -> all outputs 0 immediately; rx_valid_o=0
//     after release.
//  T2 start=1, then 10 single-cycle RX reads of "2023211013" with pops interleaved ->
//     char_cnt 1..10, done_o=1, id_ok_o=1, busy_o=0, overflow_o=0.
//  T3 same as T2 but byte 5 = 8'h39 -> done_o=1, id_ok_o=0 after byte 10.
//  T4 no pops, 6 bytes, DEPTH=4 -> bytes 1-4 retained in order, overflow_o=1, char_cnt=6.
//     Push plus pop while full -> no overflow.
//  T5 one RX read held for 3 cycles (stall) -> char_cnt +1 only.
//     A write to RXDATA_ADDR and a read of 0x30000004 -> no capture.
//  T6 start dropped after 4 bytes -> IDLE, busy_o=0, done_o=0, 4 bytes remain poppable.
//     Restart -> counters and flags cleared.

Source files
------------

// File: rtl/id_recv_if.sv
`default_nettype none
// ============================================================================
// Module   : id_recv_if
// Purpose  : ex_to_mem load-traffic bus as seen by the ID receive snooper.
// Revision : 1.0
// ============================================================================
interface id_recv_if;
    logic        ex_mem_req;
    logic        ex_mem_we;
    logic [31:0] ex_mem_raddr;
    logic [31:0] ex_mem_rdata;

    modport master (output ex_mem_req, ex_mem_we, ex_mem_raddr, ex_mem_rdata);
    modport slave  (input  ex_mem_req, ex_mem_we, ex_mem_raddr, ex_mem_rdata);
endinterface
`default_nettype wire

// File: rtl/id_recv.sv
`default_nettype none
// ============================================================================
// Module   : id_recv
// Purpose  : Snoops UART RX data reads, buffers the bytes in a small FIFO and
//            checks the stream against the fixed student ID "2023211013".
// Revision : 1.0
// ============================================================================
module id_recv #(
    parameter logic [31:0] RXDATA_ADDR = 32'h3000_0010,
    parameter int unsigned ID_LEN      = 10,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        recv_start_i,
    id_recv_if.slave    ex_mem,
    input  logic        rx_pop_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic [3:0]  char_cnt_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        id_ok_o,
    output logic        overflow_o
);

    localparam int unsigned       C_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0]        C_LAST  = 4'(ID_LEN - 1);
    localparam logic [C_PTR_W:0]  C_ONE   = (C_PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic logic [7:0] id_char(input logic [3:0] idx);
        case (idx)
            4'd0:    id_char = 8'h32;
            4'd1:    id_char = 8'h30;
            4'd2:    id_char = 8'h32;
            4'd3:    id_char = 8'h33;
            4'd4:    id_char = 8'h32;
            4'd5:    id_char = 8'h31;
            4'd6:    id_char = 8'h31;
            4'd7:    id_char = 8'h30;
            4'd8:    id_char = 8'h31;
            4'd9:    id_char = 8'h33;
            default: id_char = 8'h00;
        endcase
    endfunction

    state_t r_state, w_state_nxt;

    logic       w_hit, r_hit_q, w_cap;
    logic [7:0] w_byte;
    logic       w_byte_bad;

    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_mismatch, w_mismatch_nxt;
    logic       r_overflow, w_overflow_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_id_ok, w_id_ok_nxt;
    logic       w_flush, w_push_req;

    logic [7:0]       r_mem [0:FIFO_DEPTH-1];
    logic [C_PTR_W:0] r_wptr, r_rptr;
    logic             w_empty, w_full, w_pop, w_push;
    logic [23:0]      w_unused_rdata;

    // A stalled read holds hit high for several cycles; only its rising edge captures.
    assign w_hit      = ex_mem.ex_mem_req & ~ex_mem.ex_mem_we &
                        (ex_mem.ex_mem_raddr == RXDATA_ADDR);
    assign w_cap      = w_hit & ~r_hit_q;
    assign w_byte     = ex_mem.ex_mem_rdata[7:0];
    assign w_byte_bad = (w_byte != id_char(r_cnt));
    assign w_unused_rdata = ex_mem.ex_mem_rdata[31:8];

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_PTR_W] != r_rptr[C_PTR_W]) &&
                     (r_wptr[C_PTR_W-1:0] == r_rptr[C_PTR_W-1:0]);
    assign w_pop   = rx_pop_i & ~w_empty;
    assign w_push  = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_hit_q    <= 1'b0;
            r_cnt      <= 4'd0;
            r_mismatch <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hit_q    <= w_hit;
            r_cnt      <= w_cnt_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_overflow <= w_overflow_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_id_ok    <= w_id_ok_nxt;
        end
    end

    // Dropping the enable wins over a coincident capture: the session is over.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mismatch_nxt = r_mismatch;
        w_overflow_nxt = r_overflow;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_id_ok_nxt    = r_id_ok;
        w_flush        = 1'b0;
        w_push_req     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (recv_start_i) begin
                    w_state_nxt    = ST_COLLECT;
                    w_cnt_nxt      = 4'd0;
                    w_mismatch_nxt = 1'b0;
                    w_overflow_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_id_ok_nxt    = 1'b0;
                    w_flush        = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (!recv_start_i) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_cap) begin
                    w_push_req = 1'b1;
                    w_cnt_nxt  = r_cnt + 4'd1;
                    if (w_byte_bad) begin
                        w_mismatch_nxt = 1'b1;
                    end
                    if (w_full && !w_pop) begin
                        w_overflow_nxt = 1'b1;
                    end
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_id_ok_nxt = ~(r_mismatch | w_byte_bad);
                    end
                end
            end
            ST_DONE: begin
                if (!recv_start_i) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                    w_id_ok_nxt = 1'b0;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_ONE;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[C_PTR_W-1:0]] <= w_byte;
        end
    end

    assign rx_valid_o = ~w_empty;
    assign rx_data_o  = w_empty ? 8'h00 : r_mem[r_rptr[C_PTR_W-1:0]];
    assign char_cnt_o = r_cnt;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign id_ok_o    = r_id_ok;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_id_recv.sv
`default_nettype none
// Bench for id_recv: directed scenarios plus random traffic, compared every cycle
// against a queue-based reference model of the receive session.
`timescale 1ns/1ps
module tb_id_recv;

    localparam logic [31:0] ADDR  = 32'h3000_0010;
    localparam int          DEPTH = 4;
    localparam int          IDLEN = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pop;
    logic [7:0] rx_data;
    logic       rx_valid, busy, done, id_ok, overflow;
    logic [3:0] char_cnt;

    id_recv_if bus ();

    id_recv #(.RXDATA_ADDR(ADDR), .ID_LEN(IDLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .recv_start_i (start),
        .ex_mem       (bus),
        .rx_pop_i     (pop),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .char_cnt_o   (char_cnt),
        .busy_o       (busy),
        .done_o       (done),
        .id_ok_o      (id_ok),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: session phase, captured-byte queue and flags.
    string        id_str = "2023211013";
    byte unsigned m_q[$];
    int           m_phase;   // 0 idle, 1 collecting, 2 finished
    int           m_cnt;
    bit           m_bad, m_ovf, m_done, m_ok, m_prev;

    task automatic model_reset();
        m_q.delete();
        m_phase = 0; m_cnt = 0;
        m_bad = 0; m_ovf = 0; m_done = 0; m_ok = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit s, input bit rq, input bit w,
                              input logic [31:0] a, input logic [7:0] b, input bit p);
        bit hit, cap, popped;
        hit    = rq && !w && (a == ADDR);
        cap    = hit && !m_prev;
        popped = p && (m_q.size() > 0);
        m_prev = hit;
        if (popped) void'(m_q.pop_front());
        if (m_phase == 0) begin
            if (s) begin
                m_phase = 1; m_q.delete(); m_cnt = 0; m_bad = 0; m_ovf = 0;
            end
        end else if (m_phase == 1) begin
            if (!s) m_phase = 0;
            else if (cap) begin
                if (b != id_str[m_cnt]) m_bad = 1;
                if (m_q.size() < DEPTH) m_q.push_back(b);
                else m_ovf = 1;
                m_cnt++;
                if (m_cnt == IDLEN) begin
                    m_phase = 2; m_done = 1; m_ok = !m_bad;
                end
            end
        end else begin
            if (!s) begin
                m_phase = 0; m_done = 0; m_ok = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("rx_valid", rx_valid, m_q.size() > 0);
        check("rx_data",  rx_data,  (m_q.size() > 0) ? m_q[0] : 8'h00);
        check("char_cnt", char_cnt, m_cnt);
        check("busy",     busy,     m_phase == 1);
        check("done",     done,     m_done);
        check("id_ok",    id_ok,    m_ok);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic cyc(input bit s, input bit rq, input bit w,
                       input logic [31:0] a, input logic [7:0] b, input bit p);
        int unsigned rr;
        rr = $urandom();
        @(negedge clk);
        start = s; pop = p;
        bus.ex_mem_req   = rq;
        bus.ex_mem_we    = w;
        bus.ex_mem_raddr = a;
        bus.ex_mem_rdata = {rr[23:0], b};
        model_step(s, rq, w, a, b, p);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input bit s, input bit p);
        cyc(s, 1'b0, 1'b0, 32'h0, 8'h00, p);
    endtask

    // One single-cycle RX read followed by a gap cycle.
    task automatic rd(input logic [7:0] b, input bit p_gap);
        cyc(1'b1, 1'b1, 1'b0, ADDR, b, 1'b0);
        idle(1'b1, p_gap);
    endtask

    task automatic restart();
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_busy", busy, 1'b0);
        compare_all();
        @(negedge clk);
        start = 1'b0; pop = 1'b0; bus.ex_mem_req = 1'b0; bus.ex_mem_we = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cur_start;
        rst = 1'b0; start = 1'b0; pop = 1'b0;
        bus.ex_mem_req = 1'b0; bus.ex_mem_we = 1'b0;
        bus.ex_mem_raddr = 32'h0; bus.ex_mem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // T1: reset mid-collection with 3 bytes held
        restart();
        for (int i = 0; i < 3; i++) rd(id_str[i], 1'b0);
        check("t1_held", rx_valid, 1'b1);
        do_reset();
        idle(1'b0, 1'b0);
        check("t1_valid_after", rx_valid, 1'b0);

        // T2: correct ID with pops between reads
        restart();
        for (int i = 0; i < IDLEN; i++) begin
            rd(id_str[i], 1'b1);
            check("t2_cnt", char_cnt, i + 1);
        end
        check("t2_done", done, 1'b1);
        check("t2_ok", id_ok, 1'b1);
        check("t2_busy", busy, 1'b0);
        check("t2_ovf", overflow, 1'b0);

        // T3: fifth character corrupted
        restart();
        for (int i = 0; i < IDLEN; i++) rd((i == 4) ? 8'h39 : id_str[i], 1'b1);
        check("t3_done", done, 1'b1);
        check("t3_ok", id_ok, 1'b0);

        // T4: overflow with no pops, then drain in order
        restart();
        for (int i = 0; i < 6; i++) rd(id_str[i], 1'b0);
        check("t4_ovf", overflow, 1'b1);
        check("t4_cnt", char_cnt, 6);
        for (int i = 0; i < 4; i++) begin
            check("t4_order", rx_data, id_str[i]);
            idle(1'b1, 1'b1);
        end
        check("t4_empty", rx_valid, 1'b0);
        restart();
        for (int i = 0; i < 4; i++) rd(id_str[i], 1'b0);
        cyc(1'b1, 1'b1, 1'b0, ADDR, id_str[4], 1'b1);
        check("t4_pushpop_ovf", overflow, 1'b0);
        check("t4_pushpop_head", rx_data, id_str[1]);

        // T5: stalled read counts once; write and other address ignored
        restart();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, ADDR, id_str[0], 1'b0);
        idle(1'b1, 1'b0);
        check("t5_stall", char_cnt, 1);
        cyc(1'b1, 1'b1, 1'b1, ADDR, id_str[1], 1'b0);
        idle(1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h3000_0004, id_str[1], 1'b0);
        idle(1'b1, 1'b0);
        check("t5_nocap", char_cnt, 1);

        // T6: abort after 4 bytes, drain, restart
        restart();
        for (int i = 0; i < 4; i++) rd(id_str[i], 1'b0);
        idle(1'b0, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t6_drain", rx_data, id_str[i]);
            idle(1'b0, 1'b1);
        end
        idle(1'b1, 1'b0);
        check("t6_cnt_clr", char_cnt, 0);
        check("t6_busy_on", busy, 1'b1);

        // Random traffic
        cur_start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            int unsigned ra, rb;
            logic [31:0] a;
            logic [7:0]  b;
            if ($urandom_range(0, 999) < 2) do_reset();
            if ($urandom_range(0, 99) < 3) cur_start = ~cur_start;
            ra = $urandom_range(0, 99);
            a  = (ra < 70) ? ADDR : (ra < 85) ? 32'h3000_0004 : $urandom();
            rb = $urandom_range(0, 99);
            b  = (rb < 85) ? id_str[m_cnt % IDLEN] : 8'($urandom());
            cyc(cur_start, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                a, b, $urandom_range(0, 9) < 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
